param_skew_feeder: RTL and testbench

PARAM_SKEW_FEEDER -- requirements
Module: param_skew_feeder

---
 rtl/param_skew_feeder.sv | 127 ++++++++++++
 tb/tb_param_skew_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/param_skew_feeder.sv
// Systolic-array edge feeder: delays lane c of each accepted vector by c cycles
// (MODE=0, skew) or N-1-c cycles (MODE=1, deskew). Optional macro SKEW_BEAT_COUNT_EN adds a 16-bit accept counter.
module param_skew_feeder #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MODE       = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic                                        in_valid,
    input  logic                                        in_last,
    output logic                                        in_ready,
    input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_data,
    output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out_data,
    output logic        [ARRAY_SIZE-1:0]                 out_lane_valid,
`ifdef SKEW_BEAT_COUNT_EN
    output logic        [15:0]                           beat_count,
`endif
    output logic                                        dbg_state,
    output logic                                        done
);

    localparam int CNT_W = (ARRAY_SIZE > 2) ? $clog2(ARRAY_SIZE - 1) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    // Handshake: a vector is taken when in_valid && in_ready in a cycle without
    // flush; in_ready drops only while the last vector drains through the lanes.
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic               accept;

    assign in_ready  = (state_q == S_IDLE);
    // rst_n gates the zero-delay lane so outputs stay 0 while reset is held.
    assign accept    = in_valid && in_ready && !flush && rst_n;
    assign done      = done_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && in_last) begin
                        if (ARRAY_SIZE == 1) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                            cnt_q   <= CNT_W'(ARRAY_SIZE - 2);
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
        localparam int D = (MODE == 0) ? c : ARRAY_SIZE - 1 - c;
        if (D == 0) begin : g_comb
            assign out_data[c]       = accept ? in_data[c] : '0;
            assign out_lane_valid[c] = accept;
        end else begin : g_pipe
            logic [DATA_WIDTH-1:0] data_q [D];
            logic [D-1:0]          vld_q;

            // Idle slots shift zeros, so out_data is 0 whenever the lane is invalid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) data_q[k] <= '0;
                    vld_q <= '0;
                end else if (flush) begin
                    for (int k = 0; k < D; k++) data_q[k] <= '0;
                    vld_q <= '0;
                end else begin
                    data_q[0] <= accept ? in_data[c] : '0;
                    vld_q[0]  <= accept;
                    for (int k = 1; k < D; k++) begin
                        data_q[k] <= data_q[k-1];
                        vld_q[k]  <= vld_q[k-1];
                    end
                end
            end

            assign out_data[c]       = data_q[D-1];
            assign out_lane_valid[c] = vld_q[D-1];
        end
    end

`ifdef SKEW_BEAT_COUNT_EN
    logic [15:0] beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if (flush) begin
            beat_q <= '0;
        end else if (accept) begin
            beat_q <= beat_q + 16'd1;
        end
    end

    assign beat_count = beat_q;
`endif

endmodule

// File: tb/tb_param_skew_feeder.sv
// Bench for param_skew_feeder: skew and deskew instances share one input stream
// and are compared every cycle against a per-cycle accept history model.
module tb_param_skew_feeder;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [N-1:0][W-1:0] in_data = '0;

    logic [N-1:0][W-1:0] od0, od1;
    logic [N-1:0]        ov0, ov1;
    logic                rdy0, rdy1, done0, done1, st0, st1;
`ifdef SKEW_BEAT_COUNT_EN
    logic [15:0]         bc0, bc1;
`endif

    always #5 clk = ~clk;

    param_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(W), .MODE(0)) u_skew (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy0), .in_data(in_data), .out_data(od0), .out_lane_valid(ov0),
`ifdef SKEW_BEAT_COUNT_EN
        .beat_count(bc0),
`endif
        .dbg_state(st0), .done(done0)
    );

    param_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(W), .MODE(1)) u_deskew (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy1), .in_data(in_data), .out_data(od1), .out_lane_valid(ov1),
`ifdef SKEW_BEAT_COUNT_EN
        .beat_count(bc1),
`endif
        .dbg_state(st1), .done(done1)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    int busy_until = -1;
    int done_at = -1;
    int beats = 0;
    logic                acc_ok  [MAXC];
    logic [N-1:0][W-1:0] acc_dat [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Lane c at cycle n shows what was accepted at cycle n - delay(c), if still alive.
    task automatic model_out(input int mode, output logic [N-1:0][W-1:0] d, output logic [N-1:0] v);
        d = '0;
        v = '0;
        for (int c = 0; c < N; c++) begin
            int m;
            m = n - ((mode == 0) ? c : N - 1 - c);
            if (m >= 0 && acc_ok[m] === 1'b1) begin
                d[c] = acc_dat[m][c];
                v[c] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input logic rdy);
        logic [N-1:0][W-1:0] ed;
        logic [N-1:0]        ev;
        model_out(0, ed, ev);
        chk("skew_data", od0, ed);
        chk("skew_valid", 32'(ov0), 32'(ev));
        model_out(1, ed, ev);
        chk("deskew_data", od1, ed);
        chk("deskew_valid", 32'(ov1), 32'(ev));
        chk("in_ready_skew", 32'(rdy0), 32'(rdy));
        chk("in_ready_deskew", 32'(rdy1), 32'(rdy));
        chk("done_skew", 32'(done0), 32'(n == done_at));
        chk("done_deskew", 32'(done1), 32'(n == done_at));
        chk("state_skew", 32'(st0), 32'(!rdy));
        chk("state_deskew", 32'(st1), 32'(!rdy));
`ifdef SKEW_BEAT_COUNT_EN
        chk("beat_count_skew", 32'(bc0), 32'(beats % 65536));
        chk("beat_count_deskew", 32'(bc1), 32'(beats % 65536));
`endif
    endtask

    // One clock cycle: drive at negedge, check 1 ns later, then advance the model.
    task automatic step(input logic v, input logic l, input logic f, input logic r,
                        input logic [N-1:0][W-1:0] d);
        logic rdy, acc;
        @(negedge clk);
        rst_n = r; in_valid = v; in_last = l; flush = f; in_data = d;
        #1;
        if (!r) begin
            for (int m = 0; m < MAXC; m++) acc_ok[m] = 1'b0;
            busy_until = -1;
            done_at = -1;
            beats = 0;
        end
        rdy = (n > busy_until);
        acc = v && rdy && !f && r;
        acc_ok[n] = acc;
        acc_dat[n] = d;
        check_all(rdy);
        if (acc) beats++;
        if (acc && l) begin
            busy_until = n + N - 1;
            done_at = n + N;
        end
        if (f && r) begin
            for (int m = 0; m <= n; m++) acc_ok[m] = 1'b0;
            if (busy_until > n) busy_until = n;
            if (done_at > n) done_at = -1;
            beats = 0;
        end
        n++;
    endtask

    function automatic logic [N-1:0][W-1:0] pack(input logic [W-1:0] e0, input logic [W-1:0] e1,
                                                 input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [N-1:0][W-1:0] p;
        p[0] = e0; p[1] = e1; p[2] = e2; p[3] = e3;
        return p;
    endfunction

    function automatic logic [W-1:0] rnd_elem();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            default: return W'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [N-1:0][W-1:0] rnd_vec();
        return pack(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem());
    endfunction

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b1, rnd_vec());
    endtask

    initial begin
        for (int m = 0; m < MAXC; m++) acc_ok[m] = 1'b0;

        // Reset held with valid data offered: nothing may leak through.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rnd_vec());
        idle(2);

        // Single vector through skew and deskew.
        step(1'b1, 1'b0, 1'b0, 1'b1, pack(8'd1, 8'd2, 8'd3, 8'd4));
        idle(5);

        // Signed extremes pass bit-exact.
        step(1'b1, 1'b0, 1'b0, 1'b1, pack(8'h80, 8'h7F, 8'h80, 8'h7F));
        step(1'b1, 1'b0, 1'b0, 1'b1, pack(8'h7F, 8'h80, 8'hFF, 8'h01));
        idle(4);

        // Four back-to-back with last on the 4th, then keep offering data.
        for (int i = 0; i < 4; i++) step(1'b1, (i == 3), 1'b0, 1'b1, rnd_vec());
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, rnd_vec());
        idle(5);

        // Flush one cycle after an accept, with valid also offered.
        step(1'b1, 1'b0, 1'b0, 1'b1, pack(8'd9, 8'd10, 8'd11, 8'd12));
        step(1'b1, 1'b1, 1'b1, 1'b1, rnd_vec());
        idle(4);

        // Flush in the middle of a drain cancels the done pulse.
        step(1'b1, 1'b1, 1'b0, 1'b1, rnd_vec());
        step(1'b1, 1'b0, 1'b0, 1'b1, rnd_vec());
        step(1'b0, 1'b0, 1'b1, 1'b1, rnd_vec());
        idle(5);

        // Reset asserted mid-drain.
        step(1'b1, 1'b1, 1'b0, 1'b1, rnd_vec());
        step(1'b0, 1'b0, 1'b0, 1'b1, rnd_vec());
        step(1'b0, 1'b0, 1'b0, 1'b0, rnd_vec());
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_vec());
        idle(6);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 63) != 0, rnd_vec());
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
